// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: dual-clock FIFO read-side controller (pointers, flags, level, standard/FWFT output)
module fifo_rd_ctrl #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 16,
   parameter int AE_THRESH  = 2,
   parameter int FWFT       = 0
) (
   input  logic                  r_clk,
   input  logic                  r_rst,
   input  logic                  r_inc,
   input  logic [ADDR_WIDTH:0]   sync_wr_ptr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [ADDR_WIDTH:0]   gray_rd_ptr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   rd_level,
   output logic                  underflow
);
   localparam int PW = ADDR_WIDTH + 1;
   localparam logic FW = FWFT != 0;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, gray_q, wr_bin;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic valid_q, valid_d, uf_q, uf_d, mem_empty, fetch;
   always_comb begin
      wr_bin = '0;
      for (int i = 0; i < PW; i++) wr_bin[i] = ^(sync_wr_ptr >> i);
      mem_empty = sync_wr_ptr == (rd_ptr_q ^ (rd_ptr_q >> 1));
      fetch = !mem_empty & (FW ? (!valid_q | r_inc) : r_inc);
      empty = FW ? !valid_q : mem_empty;
      rd_ptr_d = rd_ptr_q + PW'(fetch);
      data_d = fetch ? mem_rdata : data_q;
      // in FWFT mode the head register stays full until popped without a refill
      valid_d = fetch | (FW & valid_q & !r_inc);
      uf_d = uf_q | (r_inc & empty);
      rd_level = wr_bin - rd_ptr_q + PW'(FW & valid_q);
      almost_empty = rd_level <= PW'(AE_THRESH);
   end
   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         rd_ptr_q <= '0;
         gray_q <= '0;
         data_q <= '0;
         valid_q <= 1'b0;
         uf_q <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         gray_q <= rd_ptr_d ^ (rd_ptr_d >> 1);
         data_q <= data_d;
         valid_q <= valid_d;
         uf_q <= uf_d;
      end
   end
   assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];
   assign gray_rd_ptr = gray_q;
   assign rd_data = data_q;
   assign rd_valid = valid_q;
   assign underflow = uf_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: standard-mode and FWFT instances checked against a queue-based FIFO model
module tb_fifo_rd_ctrl;
   logic r_clk = 1'b0;
   logic r_rst;
   logic inc [2];
   logic [3:0] swp [2];
   logic [15:0] mem [2][8];
   logic [2:0] addr [2];
   logic [15:0] rdat [2], dout [2];
   logic [3:0] gptr [2], lvl [2];
   logic vld [2], emp [2], ae [2], uf [2];
   int wc [2];
   int total = 0, bad = 0;

   always #5 r_clk = ~r_clk;
   assign rdat[0] = mem[0][addr[0]];
   assign rdat[1] = mem[1][addr[1]];

   fifo_rd_ctrl #(.FWFT(0)) u0 (.r_clk(r_clk), .r_rst(r_rst), .r_inc(inc[0]), .sync_wr_ptr(swp[0]),
      .mem_rdata(rdat[0]), .rd_addr(addr[0]), .gray_rd_ptr(gptr[0]), .rd_data(dout[0]), .rd_valid(vld[0]),
      .empty(emp[0]), .almost_empty(ae[0]), .rd_level(lvl[0]), .underflow(uf[0]));
   fifo_rd_ctrl #(.FWFT(1)) u1 (.r_clk(r_clk), .r_rst(r_rst), .r_inc(inc[1]), .sync_wr_ptr(swp[1]),
      .mem_rdata(rdat[1]), .rd_addr(addr[1]), .gray_rd_ptr(gptr[1]), .rd_data(dout[1]), .rd_valid(vld[1]),
      .empty(emp[1]), .almost_empty(ae[1]), .rd_level(lvl[1]), .underflow(uf[1]));

   function automatic logic [3:0] g(int n);
      logic [3:0] b = 4'(n);
      return b ^ (b >> 1);
   endfunction

   task automatic step();
      @(posedge r_clk);
      #1;
   endtask

   task automatic wr(int d, int n);
      for (int i = 0; i < n; i++) begin
         mem[d][3'(wc[d])] = 16'($urandom);
         wc[d]++;
         swp[d] = g(wc[d]);
      end
   endtask

   task automatic reset_all();
      r_rst = 1'b1;
      inc[0] = 1'b0; inc[1] = 1'b0;
      swp[0] = '0; swp[1] = '0;
      wc[0] = 0; wc[1] = 0;
      step();
      r_rst = 1'b0;
   endtask

   task automatic test_reset();
      reset_all();
      for (int d = 0; d < 2; d++) begin
         total++; if (emp[d] !== 1'b1) begin bad++; $display("FAIL rst_empty d=%0d: got %b want 1", d, emp[d]); end
         total++; if (lvl[d] !== 4'd0) begin bad++; $display("FAIL rst_level d=%0d: got %0d want 0", d, lvl[d]); end
         total++; if (ae[d] !== 1'b1) begin bad++; $display("FAIL rst_ae d=%0d: got %b want 1", d, ae[d]); end
         total++; if (vld[d] !== 1'b0) begin bad++; $display("FAIL rst_valid d=%0d: got %b want 0", d, vld[d]); end
         total++; if (gptr[d] !== 4'd0) begin bad++; $display("FAIL rst_gray d=%0d: got %h want 0", d, gptr[d]); end
         total++; if (uf[d] !== 1'b0) begin bad++; $display("FAIL rst_uf d=%0d: got %b want 0", d, uf[d]); end
         total++; if (dout[d] !== 16'd0) begin bad++; $display("FAIL rst_data d=%0d: got %h want 0", d, dout[d]); end
         total++; if (addr[d] !== 3'd0) begin bad++; $display("FAIL rst_addr d=%0d: got %0d want 0", d, addr[d]); end
      end
   endtask

   task automatic test_std_read();
      reset_all();
      wr(0, 3);
      inc[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         total++; if (vld[0] !== (k < 3)) begin bad++; $display("FAIL std_valid k=%0d: got %b want %b", k, vld[0], k < 3); end
         if (k < 3) begin
            total++; if (dout[0] !== mem[0][k]) begin bad++; $display("FAIL std_data k=%0d: got %h want %h", k, dout[0], mem[0][k]); end
         end
         total++; if (uf[0] !== (k == 3)) begin bad++; $display("FAIL std_uf k=%0d: got %b want %b", k, uf[0], k == 3); end
      end
      inc[0] = 1'b0;
      #1;
      total++; if (addr[0] !== 3'd3) begin bad++; $display("FAIL std_addr: got %0d want 3", addr[0]); end
      total++; if (gptr[0] !== 4'b0010) begin bad++; $display("FAIL std_gray: got %b want 0010", gptr[0]); end
   endtask

   task automatic test_wrap();
      logic [3:0] prev;
      reset_all();
      prev = gptr[0];
      for (int i = 0; i < 12; i++) begin
         wr(0, 1);
         inc[0] = 1'b1;
         #1;
         total++; if (addr[0] !== 3'(i)) begin bad++; $display("FAIL wrap_addr i=%0d: got %0d want %0d", i, addr[0], i % 8); end
         step();
         inc[0] = 1'b0;
         total++; if (vld[0] !== 1'b1 || dout[0] !== mem[0][i % 8]) begin bad++; $display("FAIL wrap_data i=%0d: got %b/%h want 1/%h", i, vld[0], dout[0], mem[0][i % 8]); end
         total++; if (gptr[0] !== g(i + 1)) begin bad++; $display("FAIL wrap_gray i=%0d: got %b want %b", i, gptr[0], g(i + 1)); end
         total++; if ($countones(gptr[0] ^ prev) != 1) begin bad++; $display("FAIL wrap_onebit i=%0d: got %b prev %b want one bit change", i, gptr[0], prev); end
         prev = gptr[0];
      end
      total++; if (gptr[0] !== 4'b1010) begin bad++; $display("FAIL wrap_gray_end: got %b want 1010", gptr[0]); end
      total++; if (emp[0] !== 1'b1) begin bad++; $display("FAIL wrap_empty: got %b want 1", emp[0]); end
   endtask

   task automatic test_almost_empty();
      reset_all();
      wr(0, 4);
      for (int l = 4; l >= 0; l--) begin
         #1;
         total++; if (lvl[0] !== 4'(l)) begin bad++; $display("FAIL ae_level l=%0d: got %0d want %0d", l, lvl[0], l); end
         total++; if (ae[0] !== (l <= 2)) begin bad++; $display("FAIL ae_flag l=%0d: got %b want %b", l, ae[0], l <= 2); end
         if (l > 0) begin
            inc[0] = 1'b1;
            step();
            inc[0] = 1'b0;
         end
      end
   endtask

   task automatic test_fwft();
      reset_all();
      wr(1, 5);
      #1;
      total++; if (lvl[1] !== 4'd5 || vld[1] !== 1'b0) begin bad++; $display("FAIL fwft_pre: got lvl=%0d v=%b want 5/0", lvl[1], vld[1]); end
      step();
      total++; if (vld[1] !== 1'b1 || dout[1] !== mem[1][0]) begin bad++; $display("FAIL fwft_head: got %b/%h want 1/%h", vld[1], dout[1], mem[1][0]); end
      total++; if (lvl[1] !== 4'd5) begin bad++; $display("FAIL fwft_level: got %0d want 5", lvl[1]); end
      inc[1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         total++; if (vld[1] !== 1'b1 || dout[1] !== mem[1][k]) begin bad++; $display("FAIL fwft_pop k=%0d: got %b/%h want 1/%h", k, vld[1], dout[1], mem[1][k]); end
         step();
      end
      total++; if (vld[1] !== 1'b0 || emp[1] !== 1'b1) begin bad++; $display("FAIL fwft_drain: got v=%b e=%b want 0/1", vld[1], emp[1]); end
      total++; if (uf[1] !== 1'b0) begin bad++; $display("FAIL fwft_uf: got %b want 0", uf[1]); end
      inc[1] = 1'b0;
   endtask

   task automatic test_reset_mid();
      reset_all();
      wr(1, 5);
      step();
      inc[1] = 1'b1;
      inc[0] = 1'b1;
      step();
      total++; if (vld[1] !== 1'b1 || uf[0] !== 1'b1) begin bad++; $display("FAIL mid_pre: got v=%b uf0=%b want 1/1", vld[1], uf[0]); end
      r_rst = 1'b1;
      step();
      total++; if (vld[1] !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", vld[1]); end
      total++; if (addr[1] !== 3'd0 || gptr[1] !== 4'd0) begin bad++; $display("FAIL mid_ptr: got a=%0d g=%b want 0/0", addr[1], gptr[1]); end
      total++; if (dout[1] !== 16'd0) begin bad++; $display("FAIL mid_data: got %h want 0", dout[1]); end
      total++; if (uf[0] !== 1'b0 || uf[1] !== 1'b0) begin bad++; $display("FAIL mid_uf: got %b%b want 00", uf[0], uf[1]); end
      reset_all();
   endtask

   task automatic test_random();
      logic [15:0] q0 [$], q1 [$];
      logic [15:0] w, ed0, hd;
      bit ev0, hv, u0e, u1e;
      int rc0, rc1;
      reset_all();
      ev0 = 0; hv = 0; u0e = 0; u1e = 0; ed0 = '0; hd = '0; rc0 = 0; rc1 = 0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 2) != 0 && q0.size() < 8) begin
            w = 16'($urandom); mem[0][3'(wc[0])] = w; q0.push_back(w); wc[0]++; swp[0] = g(wc[0]);
         end
         if ($urandom_range(0, 2) != 0 && q1.size() + int'(hv) < 8) begin
            w = 16'($urandom); mem[1][3'(wc[1])] = w; q1.push_back(w); wc[1]++; swp[1] = g(wc[1]);
         end
         inc[0] = $urandom_range(0, 3) != 0;
         inc[1] = $urandom_range(0, 3) != 0;
         #1;
         total++; if (emp[0] !== (q0.size() == 0) || lvl[0] !== 4'(q0.size()) || ae[0] !== (q0.size() <= 2)) begin bad++; $display("FAIL rnd0_flags c=%0d: got e=%b l=%0d ae=%b want size %0d", c, emp[0], lvl[0], ae[0], q0.size()); end
         total++; if (addr[0] !== 3'(rc0) || gptr[0] !== g(rc0)) begin bad++; $display("FAIL rnd0_ptr c=%0d: got a=%0d g=%b want reads %0d", c, addr[0], gptr[0], rc0); end
         total++; if (emp[1] !== !hv || lvl[1] !== 4'(q1.size() + int'(hv)) || ae[1] !== (q1.size() + int'(hv) <= 2)) begin bad++; $display("FAIL rnd1_flags c=%0d: got e=%b l=%0d ae=%b want head %b size %0d", c, emp[1], lvl[1], ae[1], hv, q1.size()); end
         total++; if (addr[1] !== 3'(rc1) || gptr[1] !== g(rc1)) begin bad++; $display("FAIL rnd1_ptr c=%0d: got a=%0d g=%b want reads %0d", c, addr[1], gptr[1], rc1); end
         if (inc[0] && q0.size() > 0) begin ev0 = 1; ed0 = q0.pop_front(); rc0++; end
         else ev0 = 0;
         if (inc[0] && q0.size() == 0 && !ev0) u0e = 1;
         if (inc[1] && !hv) u1e = 1;
         if (q1.size() > 0 && (!hv || inc[1])) begin hd = q1.pop_front(); hv = 1; rc1++; end
         else if (inc[1]) hv = 0;
         step();
         total++; if (vld[0] !== ev0 || dout[0] !== ed0 || uf[0] !== u0e) begin bad++; $display("FAIL rnd0_out c=%0d: got v=%b d=%h uf=%b want %b/%h/%b", c, vld[0], dout[0], uf[0], ev0, ed0, u0e); end
         total++; if (vld[1] !== hv || dout[1] !== hd || uf[1] !== u1e) begin bad++; $display("FAIL rnd1_out c=%0d: got v=%b d=%h uf=%b want %b/%h/%b", c, vld[1], dout[1], uf[1], hv, hd, u1e); end
      end
      inc[0] = 1'b0; inc[1] = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int d = 0; d < 2; d++) for (int a = 0; a < 8; a++) mem[d][a] = '0;
      test_reset();
      test_std_read();
      test_wrap();
      test_almost_empty();
      test_fwft();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Parametrised read-side controller for the dual-clock FIFO, and the successor to the fixed-width read pointer block. It sits in the read clock domain between the FIFO memory (asynchronous read port) and the downstream consumer. It generates the binary read address and the gray read pointer, and flags empty, almost-empty and underflow. It also reports the read-side fill level and offers a standard mode or a first-word-fall-through (FWFT) output register.

## Interface
- ADDR_WIDTH, 3, memory address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
- DATA_WIDTH, 16, data word width
- AE_THRESH, 2, almost_empty asserts when rd_level <= AE_THRESH
- FWFT, 0, 0 = standard read mode, 1 = first-word-fall-through mode
- r_clk  in  1  read domain clock; all logic is on its rising edge
- r_rst  in  1  reset, synchronous, active-high
- r_inc  in  1  read request (FWFT=0) or pop of the head word (FWFT=1)
- sync_wr_ptr  in  ADDR_WIDTH+1  gray write pointer, already synchronised into r_clk
- mem_rdata  in  DATA_WIDTH  memory read data, combinational from rd_addr
- rd_addr  out  ADDR_WIDTH  binary read address, equal to rd_ptr[ADDR_WIDTH-1:0]
- gray_rd_ptr  out  ADDR_WIDTH+1  registered gray read pointer, sent to the write domain synchroniser
- rd_data  out  DATA_WIDTH  registered read data
- rd_valid  out  1  rd_data valid
- empty  out  1  consumer-visible empty flag
- almost_empty  out  1  fill level at or below AE_THRESH
- rd_level  out  ADDR_WIDTH+1  words available to the consumer (0..2^ADDR_WIDTH)
- underflow  out  1  sticky underflow error

## Operation
- Internal binary pointer rd_ptr, ADDR_WIDTH+1 bits, wraps modulo 2^(ADDR_WIDTH+1).
- mem_empty = (sync_wr_ptr == rd_ptr ^ (rd_ptr >> 1)), combinational.
- fetch = memory read this cycle.
  - FWFT=0: fetch = r_inc & !mem_empty.
  - FWFT=1: fetch = !mem_empty & (!rd_valid | r_inc).
- On fetch:
  - rd_ptr <= rd_ptr+1.
  - rd_data <= mem_rdata, read from the pre-increment address.
- gray_rd_ptr <= gray(next rd_ptr), so gray_rd_ptr always equals gray(rd_ptr) with no extra lag.
- FWFT=0 behaviour:
  - rd_valid <= fetch, a one-cycle pulse per accepted read.
  - rd_data holds its value between reads.
  - empty = mem_empty.
- FWFT=1 behaviour:
  - The output register holds the head word. rd_valid is the head-register state (EMPTY when 0, FULL when 1).
  - EMPTY -> FULL on fetch.
  - FULL -> FULL on r_inc with fetch (back-to-back pop and refill).
  - FULL -> EMPTY on r_inc without fetch.
  - FULL holds when there is no r_inc.
  - empty = !rd_valid.
- Level:
  - wr_bin = gray-to-binary(sync_wr_ptr).
  - mem_level = wr_bin - rd_ptr, modulo 2^(ADDR_WIDTH+1).
  - rd_level = mem_level + (FWFT ? rd_valid : 0), combinational.
- almost_empty = (rd_level <= AE_THRESH), combinational.
- Underflow:
  - underflow <= 1 when r_inc & empty. It stays set until r_rst.
  - An underflow request never moves rd_ptr and never changes rd_data or rd_valid state beyond the normal rules.
- Reset values (r_rst sampled high):
  - rd_ptr = 0, gray_rd_ptr = 0, rd_data = 0, rd_valid = 0, underflow = 0.
  - empty = 1 when sync_wr_ptr == 0.
  - rd_addr = 0.
- Reset mid-operation discards the head word and any pending request in the same cycle. Reset has priority over fetch and underflow.

## Timing
- FWFT=0: r_inc in cycle t with mem_empty=0 gives rd_valid=1 and the word in rd_data in cycle t+1. This sustains one word per cycle.
- FWFT=1 head word: the first word written appears with rd_valid=1 one cycle after mem_empty falls. Pop throughput is one word per cycle while the memory is non-empty.
- Pointer updates:
  - gray_rd_ptr and rd_addr update at the edge ending the fetch cycle.
  - empty, almost_empty and rd_level follow sync_wr_ptr combinationally, within the same cycle.
- Wrap-around: rd_ptr advances 2^(ADDR_WIDTH+1)-1 -> 0. gray_rd_ptr changes exactly one bit per increment, including at the wrap.

## Test plan
- Reset with sync_wr_ptr=0 -> empty=1, rd_level=0, almost_empty=1, rd_valid=0, gray_rd_ptr=0, underflow=0.
- FWFT=0, write pointer stepped to gray(3)=4'b0010, then r_inc held for 4 cycles:
  - rd_valid pulses for 3 cycles, carrying data from addresses 0, 1, 2.
  - The 4th request sets underflow=1 and leaves rd_ptr=3.
- FWFT=0, 12 writes and 12 reads interleaved, where pointers wrap past 8:
  - rd_addr sequence 0..7, 0..3.
  - gray_rd_ptr reaches 4'b1010 (gray of 12).
  - Exactly one gray bit changes per step.
  - empty=1 at the end.
- FWFT=1, sync_wr_ptr set to gray(5) with r_inc=0:
  - Next cycle rd_valid=1 with the address-0 word; rd_level=5.
  - Holding r_inc=1 then yields words 0..4 on consecutive cycles.
  - rd_valid falls after the 5th pop, followed by empty=1.
- AE_THRESH=2, level swept 4->0 by reads: almost_empty=0 at levels 4 and 3, and 1 at levels 2, 1 and 0.
- Reset asserted mid-burst in FWFT=1 with rd_valid=1 -> next cycle rd_valid=0, rd_ptr=0, underflow=0, rd_data=0.
